hilo_writeback: RTL and testbench

- Sits directly downstream of the shift-add multiplier and the divider.
- Owns the architectural HI/LO registers.
- Tracks the outstanding multiply/divide, commits its result into HI/LO on completion, and serves MFHI/MFLO/MTHI/MTLO.
- Raises stall toward the control unit while a result is pending, and flags divide-by-zero and timeout errors.

---
 rtl/hilo_writeback_pkg.sv | 42 ++++
 rtl/hilo_timeout_cnt.sv | 34 +++
 rtl/hilo_writeback.sv | 135 +++++++++++++
 tb/tb_hilo_writeback.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_writeback_pkg.sv
// Shared types and constants for the HI/LO writeback block and its
// multiplier/divider neighbours.
package hilo_writeback_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HILO_W = 64;

  // Multiplier end count; the timeout must sit strictly above it.
  localparam int unsigned MULT_LATENCY = 33;
  localparam int unsigned DIV_LATENCY  = 33;
  localparam int unsigned TIMEOUT_DEF  = 40;
  localparam int unsigned CNT_W_DEF    = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MULT = 2'd1,
    WAIT_DIV  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // Splits a 64-bit product into its HI (upper) and LO (lower) halves.
  function automatic hilo_t split_product(input logic [HILO_W-1:0] product);
    hilo_t r;
    r.hi = product[HILO_W-1:DATA_W];
    r.lo = product[DATA_W-1:0];
    return r;
  endfunction

  // Divider commits remainder to HI and quotient to LO.
  function automatic hilo_t pack_divide(input logic [DATA_W-1:0] quot,
                                        input logic [DATA_W-1:0] rem);
    hilo_t r;
    r.hi = rem;
    r.lo = quot;
    return r;
  endfunction

endpackage

// File: rtl/hilo_timeout_cnt.sv
// Wait-cycle counter: cleared while idle, counts while waiting, and holds
// at TIMEOUT-1 so it can never wrap.
module hilo_timeout_cnt
  import hilo_writeback_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned LAST = TIMEOUT - 1;

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last  = (count == CNT_W'(LAST));
  assign expire_c = at_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_last) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hilo_writeback.sv
// Owns architectural HI/LO: commits multiply/divide results, serves
// MFHI/MFLO/MTHI/MTLO, stalls control while a result is outstanding.
module hilo_writeback
  import hilo_writeback_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic              mult_done,
  input  logic [HILO_W-1:0] mult_result,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quot,
  input  logic [DATA_W-1:0] div_rem,
  input  logic              div_zero,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mfhi,
  input  logic              mflo,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall,
  output logic              div_zero_exc,
  output logic              timeout_err
);

  state_e state;
  logic   waiting_c;
  logic   done_c;
  logic   expire_c;
  logic   any_req_c;
  hilo_t  mult_hilo_c;
  hilo_t  div_hilo_c;

  assign waiting_c   = (state == WAIT_MULT) || (state == WAIT_DIV);
  assign done_c      = ((state == WAIT_MULT) && mult_done) ||
                       ((state == WAIT_DIV)  && div_done);
  assign mult_hilo_c = split_product(mult_result);
  assign div_hilo_c  = pack_divide(div_quot, div_rem);

  hilo_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (!waiting_c),
    .enable   (waiting_c && !done_c),
    .expire_c (expire_c)
  );

  // Requests are held off while busy; control repeats them afterwards.
  assign any_req_c = mfhi | mflo | mthi | mtlo | start_mult | start_div;
  assign stall     = busy & any_req_c;

  // mfhi wins over mflo; read is straight off the registered HI/LO.
  always_comb begin
    rd_data = '0;
    if (mfhi) begin
      rd_data = hi;
    end else if (mflo) begin
      rd_data = lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      hi           <= '0;
      lo           <= '0;
      busy         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) begin
            hi <= wdata;
          end
          if (mtlo) begin
            lo <= wdata;
          end
          if (start_mult) begin
            state <= WAIT_MULT;
            busy  <= 1'b1;
          end else if (start_div) begin
            state <= WAIT_DIV;
            busy  <= 1'b1;
          end
        end
        WAIT_MULT: begin
          if (mult_done) begin
            hi    <= mult_hilo_c.hi;
            lo    <= mult_hilo_c.lo;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (expire_c) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        WAIT_DIV: begin
          if (div_done) begin
            if (div_zero) begin
              div_zero_exc <= 1'b1;
            end else begin
              hi <= div_hilo_c.hi;
              lo <= div_hilo_c.lo;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else if (expire_c) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_writeback.sv
// Directed bench for hilo_writeback with hand-computed expectations.
module tb_hilo_writeback;

  logic        clk;
  logic        reset_n;
  logic        start_mult;
  logic        start_div;
  logic        mult_done;
  logic [63:0] mult_result;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_zero;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        div_zero_exc;
  logic        timeout_err;

  int total;
  int bad;

  hilo_writeback #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_mult   (start_mult),
    .start_div    (start_div),
    .mult_done    (mult_done),
    .mult_result  (mult_result),
    .div_done     (div_done),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .div_zero     (div_zero),
    .mthi         (mthi),
    .mtlo         (mtlo),
    .wdata        (wdata),
    .mfhi         (mfhi),
    .mflo         (mflo),
    .rd_data      (rd_data),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .stall        (stall),
    .div_zero_exc (div_zero_exc),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    start_mult = 0; start_div = 0; mult_done = 0; mult_result = '0;
    div_done = 0; div_quot = '0; div_rem = '0; div_zero = 0;
    mthi = 0; mtlo = 0; wdata = '0; mfhi = 0; mflo = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset_n = 0;
    tick(2);
    reset_n = 1;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_dzx", 64'(div_zero_exc), 64'h0);
    chk("rst_terr", 64'(timeout_err), 64'h0);

    // Basic multiply with mflo held from cycle 2 until it is accepted
    start_mult = 1;
    tick();
    start_mult = 0;
    chk("mul_busy", 64'(busy), 64'h1);
    tick();
    mflo = 1;
    #1;
    chk("mul_stall_c1", 64'(stall), 64'h1);
    for (int i = 2; i < 33; i++) begin
      tick();
      chk("mul_stall_loop", 64'(stall), 64'h1);
    end
    mult_done   = 1;
    mult_result = 64'h0000_0001_FFFF_FFFE;
    #1;
    chk("mul_stall_done", 64'(stall), 64'h1);
    tick();
    mult_done   = 0;
    mult_result = '0;
    chk("mul_hi", 64'(hi), 64'h1);
    chk("mul_lo", 64'(lo), 64'hFFFF_FFFE);
    chk("mul_busy_end", 64'(busy), 64'h0);
    chk("mul_stall_end", 64'(stall), 64'h0);
    chk("mflo_rd", 64'(rd_data), 64'hFFFF_FFFE);
    mflo = 0; mfhi = 1;
    #1;
    chk("mfhi_rd", 64'(rd_data), 64'h1);
    mflo = 1;
    #1;
    chk("mfhi_prio", 64'(rd_data), 64'h1);
    mfhi = 0; mflo = 0;
    #1;
    chk("rd_none", 64'(rd_data), 64'h0);

    // Divide, then divide by zero
    start_div = 1;
    tick();
    start_div = 0;
    chk("div_busy", 64'(busy), 64'h1);
    tick(3);
    div_done = 1; div_quot = 32'd7; div_rem = 32'd3;
    tick();
    div_done = 0;
    chk("div_hi", 64'(hi), 64'd3);
    chk("div_lo", 64'(lo), 64'd7);
    chk("div_busy_end", 64'(busy), 64'h0);
    chk("div_dzx0", 64'(div_zero_exc), 64'h0);
    start_div = 1;
    tick();
    start_div = 0;
    tick(2);
    div_done = 1; div_zero = 1; div_quot = 32'd9; div_rem = 32'd9;
    tick();
    div_done = 0; div_zero = 0;
    chk("dz_exc", 64'(div_zero_exc), 64'h1);
    chk("dz_hi", 64'(hi), 64'd3);
    chk("dz_lo", 64'(lo), 64'd7);
    chk("dz_busy", 64'(busy), 64'h0);
    tick();
    chk("dz_exc_pulse", 64'(div_zero_exc), 64'h0);

    // Timeout: error pulse 40 edges after the start edge
    start_mult = 1;
    tick();
    start_mult = 0;
    tick(39);
    chk("to_busy39", 64'(busy), 64'h1);
    chk("to_terr39", 64'(timeout_err), 64'h0);
    tick();
    chk("to_terr", 64'(timeout_err), 64'h1);
    chk("to_busy", 64'(busy), 64'h0);
    chk("to_hi", 64'(hi), 64'd3);
    chk("to_lo", 64'(lo), 64'd7);
    tick();
    chk("to_terr_pulse", 64'(timeout_err), 64'h0);

    // Done arriving on the timeout cycle commits normally
    start_mult = 1;
    tick();
    start_mult = 0;
    tick(39);
    mult_done = 1; mult_result = 64'h1234_5678_9ABC_DEF0;
    tick();
    mult_done = 0;
    chk("tod_hi", 64'(hi), 64'h1234_5678);
    chk("tod_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("tod_terr", 64'(timeout_err), 64'h0);
    chk("tod_busy", 64'(busy), 64'h0);

    // Both starts: multiply wins, div_done ignored
    start_mult = 1; start_div = 1;
    tick();
    start_mult = 0; start_div = 0;
    tick(2);
    div_done = 1; div_quot = 32'h5555_5555; div_rem = 32'h6666_6666;
    tick();
    div_done = 0;
    chk("both_busy", 64'(busy), 64'h1);
    chk("both_hi", 64'(hi), 64'h1234_5678);
    mthi = 1; wdata = 32'h1111_1111;
    #1;
    chk("busy_mthi_stall", 64'(stall), 64'h1);
    tick();
    mthi = 0;
    mult_done = 1; mult_result = 64'hCAFE_F00D_DEAD_BEEF;
    tick();
    mult_done = 0;
    chk("both_mhi", 64'(hi), 64'hCAFE_F00D);
    chk("both_mlo", 64'(lo), 64'hDEAD_BEEF);

    // mthi and mtlo together in IDLE
    mthi = 1; mtlo = 1; wdata = 32'hA5A5_A5A5;
    tick();
    mthi = 0; mtlo = 0;
    chk("mt_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mt_lo", 64'(lo), 64'hA5A5_A5A5);

    // Reset on cycle 10 of a multiply, late done ignored
    start_mult = 1;
    tick();
    start_mult = 0;
    tick(9);
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("rmid_hi", 64'(hi), 64'h0);
    chk("rmid_lo", 64'(lo), 64'h0);
    chk("rmid_busy", 64'(busy), 64'h0);
    tick(22);
    mult_done = 1; mult_result = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mult_done = 0;
    chk("late_hi", 64'(hi), 64'h0);
    chk("late_lo", 64'(lo), 64'h0);
    chk("late_busy", 64'(busy), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
